// File: rtl/instr_fetch_cache_if.sv
// CPU fetch port and PSRAM read channel of the instruction fetch cache.
// master: the cache side; slave: the CPU/memory environment.
interface instr_fetch_cache_if;
    logic [31:2] pc;
    logic        fetch_req;
    logic        invalidate;
    logic [31:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        mem_calib;
    logic        mem_cmd;
    logic        mem_cmd_en;
    logic [20:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_data_valid;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_data_mask;

    modport master (
        input  pc, fetch_req, invalidate, mem_calib, mem_rd_data, mem_rd_data_valid,
        output instr, instr_valid, busy, mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, mem_data_mask
    );

    modport slave (
        output pc, fetch_req, invalidate, mem_calib, mem_rd_data, mem_rd_data_valid,
        input  instr, instr_valid, busy, mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, mem_data_mask
    );
endinterface

// File: rtl/instr_fetch_cache.sv
// Direct-mapped one-word-per-line instruction cache in front of a PSRAM read channel.
// Optional hit/miss counters are built in with macro FETCH_CACHE_STATS_EN.
module instr_fetch_cache #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_cache_if.master bus
`ifdef FETCH_CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 19 - INDEX_BITS;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, FILL} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES];
    logic [TW-1:0]           cnt_q;
    logic                    pend_q;
    logic [20:0]             mem_addr_q;
    logic                    mem_cmd_en_q;
    logic [31:0]             instr_q;
    logic                    instr_valid_q;
    logic [31:0]             fill_data_q;

    logic                    busy_c, hit_fire, miss_fire, capture, fill, cnt_inc;
    logic                    lookup_hit;
    logic [INDEX_BITS-1:0]   pc_idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, fill_tag;
    logic                    unused_pc_hi;

    // Addresses alias modulo 2 MiB, so the upper pc bits are dropped.
    assign unused_pc_hi = ^bus.pc[31:21];

    assign pc_idx     = bus.pc[INDEX_BITS+1:2];
    assign pc_tag     = bus.pc[20:INDEX_BITS+2];
    assign fill_idx   = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag   = mem_addr_q[20:INDEX_BITS+2];
    // A same-cycle invalidate forces the lookup to miss.
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !bus.invalidate;

    // Next-state and control decode.
    always_comb begin
        state_d   = state_q;
        busy_c    = 1'b1;
        hit_fire  = 1'b0;
        miss_fire = 1'b0;
        capture   = 1'b0;
        fill      = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            INIT: begin
                if (bus.mem_calib) state_d = IDLE;
            end
            IDLE: begin
                busy_c = 1'b0;
                if (bus.fetch_req) begin
                    if (lookup_hit) begin
                        hit_fire = 1'b1;
                    end else begin
                        miss_fire = 1'b1;
                        busy_c    = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rd_data_valid) begin
                    capture = 1'b1;
                    state_d = FILL;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = ISSUE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FILL: begin
                fill    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State, control and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= INIT;
            valid_q       <= '0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_cmd_en_q  <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_inc ? cnt_q + TW'(1) : '0;
            mem_cmd_en_q  <= (state_d == ISSUE);
            instr_valid_q <= hit_fire | fill;

            if (miss_fire) mem_addr_q <= {bus.pc[20:2], 2'b00};

            if (hit_fire)  instr_q <= data_q[pc_idx];
            else if (fill) instr_q <= fill_data_q;

            if (state_q == FILL)
                pend_q <= 1'b0;
            else if (bus.invalidate && (state_q == ISSUE || state_q == WAIT))
                pend_q <= 1'b1;

            // Deferred invalidate also wipes the line being filled.
            if (state_q == INIT)
                valid_q <= '0;
            else if (fill && (pend_q || bus.invalidate))
                valid_q <= '0;
            else if (fill)
                valid_q[fill_idx] <= 1'b1;
            else if (state_q == IDLE && bus.invalidate)
                valid_q <= '0;
        end
    end

    // Line storage and capture buffer carry no reset.
    always_ff @(posedge clk) begin
        if (capture) fill_data_q <= bus.mem_rd_data;
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data_q;
        end
    end

`ifdef FETCH_CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_fire)  hit_count  <= hit_count + 32'd1;
            if (miss_fire) miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign bus.busy          = busy_c;
    assign bus.instr         = instr_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.mem_cmd       = 1'b0;
    assign bus.mem_cmd_en    = mem_cmd_en_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wr_data   = 32'h0;
    assign bus.mem_data_mask = 4'h0;

endmodule

// File: tb/tb_instr_fetch_cache.sv
// Directed self-checking bench for instr_fetch_cache (default parameters).
// Stats checks are compiled in when FETCH_CACHE_STATS_EN is defined.
module tb_instr_fetch_cache;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cmd_count = 0;
`ifdef FETCH_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    instr_fetch_cache_if bus ();

    instr_fetch_cache dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef FETCH_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.mem_cmd_en === 1'b1) cmd_count++;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Miss: strobe in cycle 1, data lat cycles after it, instr_valid at cycle 3+lat.
    task automatic miss_fetch(input logic [29:0] a, input int lat, input logic [31:0] d,
                              input int inv_at, input string tag);
        int base;
        base = cmd_count;
        bus.pc = a;
        bus.fetch_req = 1'b1;
        bus.invalidate = (inv_at == 0);
        #1 chk({tag, ".busy_c0"}, 32'(bus.busy), 32'd1);
        for (int c = 1; c <= lat + 3; c++) begin
            step();
            bus.invalidate        = (c == inv_at);
            bus.mem_rd_data_valid = (c == lat + 1);
            bus.mem_rd_data       = (c == lat + 1) ? d : 32'h0;
            if (c == lat + 3) bus.fetch_req = 1'b0;
            #1;
            if (c == 1) begin
                chk({tag, ".cmd_en"}, 32'(bus.mem_cmd_en), 32'd1);
                chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'({a[18:0], 2'b00}));
            end
            if (c == 2) chk({tag, ".cmd_en_off"}, 32'(bus.mem_cmd_en), 32'd0);
            if (c == lat + 2) chk({tag, ".early_valid"}, 32'(bus.instr_valid), 32'd0);
            if (c == lat + 3) begin
                chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'd1);
                chk({tag, ".instr"}, bus.instr, d);
                chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
                chk({tag, ".strobes"}, 32'(cmd_count - base), 32'd1);
            end
        end
    endtask

    task automatic hit_fetch(input logic [29:0] a, input logic [31:0] d, input string tag);
        bus.pc = a;
        bus.fetch_req = 1'b1;
        #1 chk({tag, ".busy_c0"}, 32'(bus.busy), 32'd0);
        step();
        bus.fetch_req = 1'b0;
        #1;
        chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, ".instr"}, bus.instr, d);
        chk({tag, ".cmd_en"}, 32'(bus.mem_cmd_en), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        bus.pc = '0;
        bus.fetch_req = 1'b0;
        bus.invalidate = 1'b0;
        bus.mem_calib = 1'b0;
        bus.mem_rd_data = 32'h0;
        bus.mem_rd_data_valid = 1'b0;
        repeat (2) step();
        #1;
        chk("rst.instr", bus.instr, 32'h0);
        chk("rst.instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd1);
        chk("rst.cmd_en", 32'(bus.mem_cmd_en), 32'd0);
        chk("rst.cmd", 32'(bus.mem_cmd), 32'd0);
        chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.wr_data", bus.mem_wr_data, 32'h0);
        chk("rst.mask", 32'(bus.mem_data_mask), 32'd0);
`ifdef FETCH_CACHE_STATS_EN
        chk("rst.hit_count", hit_count, 32'd0);
        chk("rst.miss_count", miss_count, 32'd0);
`endif
        reset = 1'b1;

        // Calibration pending: stay busy, issue nothing.
        for (int i = 0; i < 20; i++) begin
            step();
            #1 chk("calib.busy", 32'(bus.busy), 32'd1);
        end
        chk("calib.no_cmd", 32'(cmd_count), 32'd0);
        bus.mem_calib = 1'b1;
        #1 chk("calib.busy_same_cycle", 32'(bus.busy), 32'd1);
        step();
        #1 chk("calib.busy_released", 32'(bus.busy), 32'd0);

        miss_fetch(30'h100, 5, 32'hDEADBEEF, -1, "cold");
        hit_fetch(30'h100, 32'hDEADBEEF, "repeat");
        miss_fetch(30'h110, 3, 32'hA5A50110, -1, "conflict");
        miss_fetch(30'h100, 2, 32'hDEADBEEF, -1, "refetch");
`ifdef FETCH_CACHE_STATS_EN
        chk("stats.hit_count", hit_count, 32'd1);
        chk("stats.miss_count", miss_count, 32'd3);
`endif

        // Invalidate while waiting: data still delivered, line not kept.
        miss_fetch(30'h205, 5, 32'hCAFEF00D, 3, "inv_wait");
        miss_fetch(30'h205, 1, 32'h12345678, -1, "after_inv");
        hit_fetch(30'h205, 32'h12345678, "hit_refill");

        // No response: reissue after exactly TIMEOUT wait cycles.
        base = cmd_count;
        bus.pc = 30'h3C7;
        bus.fetch_req = 1'b1;
        #1 chk("tmo.busy_c0", 32'(bus.busy), 32'd1);
        step();
        #1 chk("tmo.first_cmd", 32'(bus.mem_cmd_en), 32'd1);
        repeat (64) step();
        #1 chk("tmo.cycle65_idle", 32'(bus.mem_cmd_en), 32'd0);
        chk("tmo.one_strobe", 32'(cmd_count - base), 32'd1);
        step();
        #1 chk("tmo.cycle66_cmd", 32'(bus.mem_cmd_en), 32'd1);
        chk("tmo.same_addr", 32'(bus.mem_addr), 32'h00000F1C);
        step();
        bus.mem_rd_data = 32'h13579BDF;
        bus.mem_rd_data_valid = 1'b1;
        step();
        bus.mem_rd_data_valid = 1'b0;
        #1 chk("tmo.fill_cycle", 32'(bus.instr_valid), 32'd0);
        step();
        bus.fetch_req = 1'b0;
        #1 chk("tmo.instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("tmo.instr", bus.instr, 32'h13579BDF);
        chk("tmo.two_strobes", 32'(cmd_count - base), 32'd2);

        // Invalidate coinciding with a fetch of a cached line forces a miss.
        miss_fetch(30'h3C7, 1, 32'h0BADF00D, 0, "inv_fetch");
        hit_fetch(30'h3C7, 32'h0BADF00D, "hit_after_inv_fetch");

        // Stray read data in IDLE is ignored.
        bus.mem_rd_data = 32'hFFFFFFFF;
        bus.mem_rd_data_valid = 1'b1;
        step();
        bus.mem_rd_data_valid = 1'b0;
        #1 chk("stray.instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("stray.instr_held", bus.instr, 32'h0BADF00D);
        chk("stray.busy", 32'(bus.busy), 32'd0);

        // Reset during a miss abandons it and clears all lines.
        bus.pc = 30'h0AA;
        bus.fetch_req = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.fetch_req = 1'b0;
        #1 chk("midrst.busy", 32'(bus.busy), 32'd1);
        chk("midrst.cmd_en", 32'(bus.mem_cmd_en), 32'd0);
        chk("midrst.instr", bus.instr, 32'h0);
        chk("midrst.mem_addr", 32'(bus.mem_addr), 32'd0);
        step();
        reset = 1'b1;
        step();
        bus.mem_rd_data = 32'h77777777;
        bus.mem_rd_data_valid = 1'b1;
        #1 chk("midrst.idle", 32'(bus.busy), 32'd0);
        step();
        bus.mem_rd_data_valid = 1'b0;
        #1 chk("midrst.late_data_ignored", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_CACHE_STATS_EN
        chk("midrst.hit_count", hit_count, 32'd0);
`endif
        miss_fetch(30'h205, 2, 32'h55AA55AA, -1, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
